// File: rtl/digitron_scan_display.sv
// rtl/digitron_scan_display.sv - multiplexed 7-segment scan driver with frame-coherent capture
// Optional blink support is built when DIGITRON_BLINK_EN is defined.
module digitron_scan_display #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     blink,
    output logic [7:0]            Digitron_Out,
    output logic [DIGITS-1:0]     DigitronCS_Out,
    output logic                  frame_start
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]       p_q, p_d;
    logic [IW-1:0]       i_q, i_d;
    logic [4*DIGITS-1:0] data_sh_q;
    logic [DIGITS-1:0]   dp_sh_q, blank_sh_q;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   cs_q, cs_d;
    logic                fs_q;
    logic                snap, wrap_p, blink_off, lit;
    logic [3:0]          code;
    logic [7:0]          glyph;

    assign snap   = enable && (p_q == '0) && (i_q == '0);
    assign wrap_p = (p_q == PW'(SCAN_DIV - 1));

    always_comb begin
        p_d = p_q;
        i_d = i_q;
        if (enable) begin
            p_d = wrap_p ? '0 : p_q + 1'b1;
            if (wrap_p)
                i_d = (i_q == IW'(DIGITS - 1)) ? '0 : i_q + 1'b1;
        end
    end

`ifdef DIGITRON_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0]     fc_q;
    logic              phase_q;
    logic [DIGITS-1:0] blink_sh_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fc_q       <= '0;
            phase_q    <= 1'b0;
            blink_sh_q <= '0;
        end else if (snap) begin
            blink_sh_q <= blink;
            if (fc_q == FW'(BLINK_FRAMES - 1)) begin
                fc_q    <= '0;
                phase_q <= ~phase_q;
            end else begin
                fc_q <= fc_q + 1'b1;
            end
        end
    end

    assign blink_off = phase_q & blink_sh_q[i_q];
`else
    logic blink_unused;
    assign blink_unused = ^blink;
    assign blink_off    = 1'b0;
`endif

    always_comb begin
        code = data_sh_q[4*i_q +: 4];
        case (code)
            4'h0: glyph = 8'h3f;
            4'h1: glyph = 8'h06;
            4'h2: glyph = 8'h5b;
            4'h3: glyph = 8'h4f;
            4'h4: glyph = 8'h66;
            4'h5: glyph = 8'h6d;
            4'h6: glyph = 8'h7d;
            4'h7: glyph = 8'h07;
            4'h8: glyph = 8'h7f;
            4'h9: glyph = 8'h6f;
            4'hA: glyph = 8'h73;
            4'hB: glyph = 8'h77;
            4'hC: glyph = 8'h6d;
            4'hD: glyph = 8'h40;
            4'hE: glyph = 8'h79;
            default: glyph = 8'h00;
        endcase
    end

    // p==0 is the deghost cycle: all digits dark while the select lines settle.
    assign lit = enable && (p_q != '0) && !blank_sh_q[i_q] && !blink_off;

    always_comb begin
        seg_d = 8'h00;
        cs_d  = '1;
        if (lit) begin
            seg_d = glyph | {dp_sh_q[i_q], 7'b0};
            cs_d  = ~(DIGITS'(1) << i_q);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            p_q        <= '0;
            i_q        <= '0;
            data_sh_q  <= '0;
            dp_sh_q    <= '0;
            blank_sh_q <= '1;
            seg_q      <= 8'h00;
            cs_q       <= '1;
            fs_q       <= 1'b0;
        end else begin
            p_q   <= p_d;
            i_q   <= i_d;
            seg_q <= seg_d;
            cs_q  <= cs_d;
            fs_q  <= snap;
            if (snap) begin
                data_sh_q  <= data;
                dp_sh_q    <= dp;
                blank_sh_q <= blank;
            end
        end
    end

    assign Digitron_Out   = seg_q;
    assign DigitronCS_Out = cs_q;
    assign frame_start    = fs_q;

endmodule

// File: tb/tb_digitron_scan_display.sv
// tb/tb_digitron_scan_display.sv - self-checking bench for digitron_scan_display
module tb_digitron_scan_display;

    localparam int D  = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FL = D * SD;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          enable = 1'b0;
    logic [15:0]   data = '0;
    logic [3:0]    dp = '0, blank = '0, blink = '0;
    logic [7:0]    Digitron_Out;
    logic [3:0]    DigitronCS_Out;
    logic          frame_start;

    digitron_scan_display #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .data(data), .dp(dp),
        .blank(blank), .blink(blink), .Digitron_Out(Digitron_Out),
        .DigitronCS_Out(DigitronCS_Out), .frame_start(frame_start)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: pos = enabled cycles since reset, nsnap = snapshots taken.
    int          pos, nsnap;
    logic [15:0] sh_data;
    logic [3:0]  sh_dp, sh_blank, sh_blink;
    logic [7:0]  glyph_tab [16];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at pos %0d: observed %h expected %h", tag, pos, obs, exp);
        end
    endtask

    task automatic model_reset();
        pos = 0; nsnap = 0;
        sh_data = '0; sh_dp = '0; sh_blank = '1; sh_blink = '0;
    endtask

    task automatic step();
        logic [7:0] es;
        logic [3:0] ec;
        logic       ef;
        int         sl, dg;
        bit         off;
        es = 8'h00; ec = 4'hf; ef = 1'b0;
        if (RST) begin
            model_reset();
        end else if (enable) begin
            sl = pos % SD;
            dg = (pos / SD) % D;
            ef = (pos % FL) == 0;
            if (ef) begin
                sh_data = data; sh_dp = dp; sh_blank = blank; sh_blink = blink;
                nsnap++;
            end
`ifdef DIGITRON_BLINK_EN
            off = sh_blink[dg] && (((nsnap / BF) % 2) == 1);
`else
            off = 1'b0;
`endif
            if (sl != 0 && !sh_blank[dg] && !off) begin
                es = glyph_tab[sh_data[4*dg +: 4]] | {sh_dp[dg], 7'b0};
                ec = ~(4'b0001 << dg);
            end
            pos++;
        end
        @(posedge CLK);
        #1;
        check("seg", Digitron_Out, es);
        check("cs", {4'b0, DigitronCS_Out}, {4'b0, ec});
        check("frame_start", {7'b0, frame_start}, {7'b0, ef});
    endtask

    initial begin
        glyph_tab = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07,
                      8'h7f, 8'h6f, 8'h73, 8'h77, 8'h6d, 8'h40, 8'h79, 8'h00};
        model_reset();

        // Reset and first frames
        enable = 1'b1; data = 16'h1234;
        repeat (2) step();
        RST = 1'b0;
        repeat (2 * FL) step();

        // Glyphs and decimal point
        data = 16'hABCD; dp = 4'b0010;
        repeat (2 * FL) step();
        dp = 4'b0000;

        // Frame coherence: change data while digit 2 is being scanned
        data = 16'h1111;
        for (int k = 0; k < 3 * FL; k++) begin
            step();
            if (k >= FL && (pos % FL) == 2 * SD + 1) break;
        end
        data = 16'h2222;
        repeat (2 * FL) step();

        // Blanking
        blank = 4'b0100;
        repeat (2 * FL) step();
        blank = 4'b0000;

        // Enable freeze mid-slot
        repeat (5) step();
        enable = 1'b0;
        repeat (10) step();
        enable = 1'b1;
        repeat (FL) step();

        // Blink
        blink = 4'b0001;
        repeat (8 * FL) step();
        blink = 4'b0000;

        // Randomised inputs and enable
        repeat (400) begin
            if ($urandom_range(7) == 0) begin
                data = 16'($urandom); dp = 4'($urandom);
                blank = 4'($urandom); blink = 4'($urandom);
            end
            enable = ($urandom_range(9) != 0);
            step();
        end
        enable = 1'b1;

        // Asynchronous reset at p=2, i=3
        for (int k = 0; k < 2 * FL; k++) begin
            if ((pos % FL) == 3 * SD + 2) break;
            step();
        end
        #2;
        RST = 1'b1;
        #1;
        check("async_seg", Digitron_Out, 8'h00);
        check("async_cs", {4'b0, DigitronCS_Out}, 8'h0f);
        check("async_fs", {7'b0, frame_start}, 8'h00);
        model_reset();
        data = 16'h1234; dp = '0; blank = '0; blink = '0;
        repeat (2) step();
        RST = 1'b0;
        repeat (2 * FL) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
